// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use / beq-operand stall and branch/jump flush control; stall counter built only with HAZARD_STALL_CNT_EN.
module hazard_detection_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic             IFIDUsesRt,
  input  logic             IFIDBeq,
  input  logic             BranchTaken,
  input  logic             Jump,
  input  logic             IDEXMemRead,
  input  logic             IDEXRegWrite,
  input  logic [4:0]       IDEXDst,
  input  logic             EXMEMMemRead,
  input  logic [4:0]       EXMEMDst,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_nxt;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic lu, ba, bl2, bl1, hazard, stall;
  assign rs_ex  = (IDEXDst != 5'd0) && (IDEXDst == IFIDRs);
  assign rt_ex  = (IDEXDst != 5'd0) && (IDEXDst == IFIDRt);
  assign rs_mem = (EXMEMDst != 5'd0) && (EXMEMDst == IFIDRs);
  assign rt_mem = (EXMEMDst != 5'd0) && (EXMEMDst == IFIDRt);
  assign lu  = IDEXMemRead && (rs_ex || (IFIDUsesRt && rt_ex));
  assign ba  = IFIDBeq && IDEXRegWrite && !IDEXMemRead && (rs_ex || rt_ex);
  assign bl2 = IFIDBeq && IDEXMemRead && (rs_ex || rt_ex);
  assign bl1 = IFIDBeq && EXMEMMemRead && (rs_mem || rt_mem);
  assign hazard = (state == RUN) && (lu || ba || bl2 || bl1);
  // stall wins over flush: an unresolved taken branch is retried after the bubble
  always_comb begin
    stall      = !rst && ((state == HOLD) || hazard);
    state_nxt  = (state == RUN && bl2) ? HOLD : RUN;
    Stall      = stall;
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IDEXBubble = stall;
    IFIDFlush  = !rst && !stall && ((BranchTaken && IFIDBeq) || Jump);
  end
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_nxt;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (stall && !(&cnt)) cnt <= cnt + 1'b1;
  assign StallCount = cnt;
`else
  assign StallCount = '0;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed scenario tasks with hand-computed expected outputs.
module tb_hazard_detection_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] IFIDRs, IFIDRt, IDEXDst, EXMEMDst;
  logic IFIDUsesRt, IFIDBeq, BranchTaken, Jump, IDEXMemRead, IDEXRegWrite, EXMEMMemRead;
  logic PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Stall;
  logic [31:0] StallCount;
  logic [4:0] o;
  int vecs = 0, errs = 0;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  localparam logic [4:0] S_STALL = 5'b10010, S_RUN = 5'b01100, S_FLUSH = 5'b01101;

  hazard_detection_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRt(IFIDUsesRt),
    .IFIDBeq(IFIDBeq), .BranchTaken(BranchTaken), .Jump(Jump), .IDEXMemRead(IDEXMemRead),
    .IDEXRegWrite(IDEXRegWrite), .IDEXDst(IDEXDst), .EXMEMMemRead(EXMEMMemRead),
    .EXMEMDst(EXMEMDst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .Stall(Stall), .StallCount(StallCount)
  );
  always #5 clk = ~clk;
  assign o = {Stall, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};

  function automatic logic [31:0] ec(input logic [31:0] n);
    return CE ? n : 32'd0;
  endfunction

  task automatic idle();
    IFIDRs = 0; IFIDRt = 0; IFIDUsesRt = 0; IFIDBeq = 0; BranchTaken = 0; Jump = 0;
    IDEXMemRead = 0; IDEXRegWrite = 0; IDEXDst = 0; EXMEMMemRead = 0; EXMEMDst = 0;
  endtask

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); IDEXMemRead = 1; IDEXDst = 2; IFIDRs = 2;
    repeat (2) @(posedge clk); cyc();
    vecs++; if (o !== S_RUN) begin $display("FAIL reset_outs got=%b want=%b", o, S_RUN); errs++; end
    vecs++; if (StallCount !== 32'd0) begin $display("FAIL reset_cnt got=%0d want=0", StallCount); errs++; end
    idle(); rst = 0; cyc();
  endtask

  task automatic test_load_use();
    idle(); IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 2; IFIDRs = 2; IFIDRt = 4; IFIDUsesRt = 1; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL lu_stall got=%b want=%b", o, S_STALL); errs++; end
    cyc(); idle(); IFIDRs = 2; IFIDRt = 4; IFIDUsesRt = 1; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL lu_release got=%b want=%b", o, S_RUN); errs++; end
    vecs++; if (StallCount !== ec(1)) begin $display("FAIL lu_cnt got=%0d want=%0d", StallCount, ec(1)); errs++; end
    idle(); IDEXMemRead = 1; IDEXDst = 4; IFIDRs = 1; IFIDRt = 4; IFIDUsesRt = 0; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL lu_rt_unused got=%b want=%b", o, S_RUN); errs++; end
    cyc();
  endtask

  task automatic test_beq_load();
    idle(); IFIDBeq = 1; IFIDUsesRt = 1; IFIDRs = 5; IFIDRt = 6; IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 5;
    EXMEMMemRead = 1; EXMEMDst = 6; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL bl2_c1 got=%b want=%b", o, S_STALL); errs++; end
    cyc(); idle(); Jump = 1; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL bl2_hold got=%b want=%b", o, S_STALL); errs++; end
    cyc(); idle(); IFIDBeq = 1; IFIDUsesRt = 1; IFIDRs = 5; IFIDRt = 6; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL bl2_done got=%b want=%b", o, S_RUN); errs++; end
    vecs++; if (StallCount !== ec(3)) begin $display("FAIL bl2_cnt got=%0d want=%0d", StallCount, ec(3)); errs++; end
    idle(); IFIDBeq = 1; IFIDUsesRt = 1; IFIDRs = 5; IFIDRt = 6; EXMEMMemRead = 1; EXMEMDst = 6; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL bl1_stall got=%b want=%b", o, S_STALL); errs++; end
    cyc(); EXMEMMemRead = 0; EXMEMDst = 0; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL bl1_release got=%b want=%b", o, S_RUN); errs++; end
    vecs++; if (StallCount !== ec(4)) begin $display("FAIL bl1_cnt got=%0d want=%0d", StallCount, ec(4)); errs++; end
    cyc();
  endtask

  task automatic test_beq_alu();
    idle(); IFIDBeq = 1; IFIDUsesRt = 1; IFIDRs = 1; IFIDRt = 7; BranchTaken = 1; IDEXRegWrite = 1; IDEXDst = 7; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL ba_stall_noflush got=%b want=%b", o, S_STALL); errs++; end
    cyc(); IDEXRegWrite = 0; IDEXDst = 0; #1;
    vecs++; if (o !== S_FLUSH) begin $display("FAIL ba_flush got=%b want=%b", o, S_FLUSH); errs++; end
    vecs++; if (StallCount !== ec(5)) begin $display("FAIL ba_cnt got=%0d want=%0d", StallCount, ec(5)); errs++; end
    cyc(); idle(); IFIDBeq = 1; IFIDRs = 1; IFIDRt = 7; BranchTaken = 0; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL beq_not_taken got=%b want=%b", o, S_RUN); errs++; end
    cyc();
  endtask

  task automatic test_zero_dst_jump();
    idle(); IDEXMemRead = 1; IDEXRegWrite = 1; IDEXDst = 0; IFIDRs = 0; IFIDRt = 0; IFIDUsesRt = 1; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL zero_dst got=%b want=%b", o, S_RUN); errs++; end
    cyc(); idle(); Jump = 1; #1;
    vecs++; if (o !== S_FLUSH) begin $display("FAIL jump_flush got=%b want=%b", o, S_FLUSH); errs++; end
    cyc(); idle(); #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL jump_after got=%b want=%b", o, S_RUN); errs++; end
    vecs++; if (StallCount !== ec(5)) begin $display("FAIL nostall_cnt got=%0d want=%0d", StallCount, ec(5)); errs++; end
    cyc();
  endtask

  task automatic test_reset_in_hold();
    idle(); IFIDBeq = 1; IFIDRs = 5; IFIDRt = 6; IDEXMemRead = 1; IDEXDst = 6; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL rh_enter got=%b want=%b", o, S_STALL); errs++; end
    cyc(); rst = 1; Jump = 1; #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL rh_reset_outs got=%b want=%b", o, S_RUN); errs++; end
    cyc(); rst = 0; idle(); #1;
    vecs++; if (o !== S_RUN) begin $display("FAIL rh_back_run got=%b want=%b", o, S_RUN); errs++; end
    vecs++; if (StallCount !== 32'd0) begin $display("FAIL rh_cnt got=%0d want=0", StallCount); errs++; end
    cyc();
  endtask

  task automatic test_saturate();
`ifdef HAZARD_STALL_CNT_EN
    force dut.cnt = 32'hFFFF_FFFF;
    cyc(); release dut.cnt;
`endif
    idle(); IDEXMemRead = 1; IDEXDst = 3; IFIDRs = 3; #1;
    vecs++; if (o !== S_STALL) begin $display("FAIL sat_stall got=%b want=%b", o, S_STALL); errs++; end
    cyc(); idle(); #1;
    vecs++; if (StallCount !== ec(32'hFFFF_FFFF) && CE) begin $display("FAIL sat_cnt got=%h want=%h", StallCount, ec(32'hFFFF_FFFF)); errs++; end
    vecs++; if (StallCount !== 32'd0 && !CE) begin $display("FAIL cnt_tied got=%h want=0", StallCount); errs++; end
    cyc();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_beq_load();
    test_beq_alu();
    test_zero_dst_jump();
    test_reset_in_hold();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

- Stall/flush controller for the 5-stage MIPS pipeline.
- Forwarding resolves operand hazards by steering mux selects; this block handles the hazards forwarding cannot cover:
  - stalls IF/ID on load-use dependences;
  - stalls on dependences of an ID-stage `beq` comparison;
  - flushes IF/ID on taken branches and jumps.
- Sits beside the ID stage; drives PC write enable, IF/ID write enable and flush, and the ID/EX bubble insert.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; single clock domain, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `IFIDRs`, `IFIDRt`  in  5 each  source registers of the instruction in ID.
- `IFIDUsesRt`  in  1  instruction in ID reads Rt (R-type, `beq`, `sw`).
- `IFIDBeq`  in  1  instruction in ID is `beq`.
- `BranchTaken`  in  1  ID-stage equality compare resolved taken.
- `Jump`  in  1  instruction in ID is `j`.
- `IDEXMemRead`, `IDEXRegWrite`  in  1 each  control bits of the instruction in EX.
- `IDEXDst`  in  5  destination of the instruction in EX.
- `EXMEMMemRead`  in  1  control bit of the instruction in MEM.
- `EXMEMDst`  in  5  destination of the instruction in MEM.
- `PCWrite`  out  1  PC update enable.
- `IFIDWrite`  out  1  IF/ID register load enable.
- `IFIDFlush`  out  1  zero IF/ID on the next edge.
- `IDEXBubble`  out  1  zero ID/EX control bits on the next edge.
- `Stall`  out  1  stall active this cycle.
- `StallCount`  out  `CNT_W`  total stall cycles since reset.

## Operation
- FSM states: `RUN`, `HOLD`. Reset state is `RUN`. Outputs are Mealy: a function of state and current inputs.
- Hazard terms are evaluated only in `RUN`. A destination of 0 never matches.
  - LU: `IDEXMemRead` && `IDEXDst` == `IFIDRs`, or (`IFIDUsesRt` && `IDEXDst` == `IFIDRt`). Requires 1 stall.
  - BA: `IFIDBeq` && `IDEXRegWrite` && !`IDEXMemRead` && `IDEXDst` matches Rs/Rt. Requires 1 stall.
  - BL2: `IFIDBeq` && `IDEXMemRead` && `IDEXDst` matches Rs/Rt. Requires 2 stalls.
  - BL1: `IFIDBeq` && `EXMEMMemRead` && `EXMEMDst` matches Rs/Rt. Requires 1 stall.
- Stall output in a cycle: `Stall`=1, `PCWrite`=0, `IFIDWrite`=0, `IDEXBubble`=1, `IFIDFlush`=0.
- `RUN` with any hazard term true: stall this cycle.
  - If BL2: go to `HOLD`.
  - Otherwise: stay in `RUN`. The next cycle re-evaluates, with the bubble now in EX.
- `HOLD`: stall unconditionally; return to `RUN` next edge; inputs ignored.
- `RUN` with no hazard: `PCWrite`=1, `IFIDWrite`=1, `IDEXBubble`=0, `IFIDFlush` = (`BranchTaken` && `IFIDBeq`) || `Jump`.
- Simultaneous events:
  - Stall has priority over flush. A taken branch whose operands are not yet ready is never flushed; it resolves after the stall.
  - BL2 and BL1 both true: take BL2 (2 cycles).
- `StallCount` increments by 1 on every edge where `Stall`=1. It saturates at all-ones and never wraps.

## Timing
- Zero-latency hazard outputs: combinational from inputs in `RUN`. Only the FSM state and the counter are registered.
- Load-use: 1 stall cycle. Load-to-`beq`: 2 stall cycles if the load is in EX, 1 if it is in MEM. ALU-to-`beq`: 1 stall cycle.
- While `rst`=1, outputs are forced to `PCWrite`=1, `IFIDWrite`=1, `IFIDFlush`=0, `IDEXBubble`=0, `Stall`=0.
- On the edge where `rst`=1: state becomes `RUN` and `StallCount` becomes 0.
- Reset asserted in `HOLD`: the remaining stall is abandoned; `RUN` on the next edge.

## Configuration
- Macro `HAZARD_STALL_CNT_EN`.
- Defined: the `StallCount` register exists and behaves as specified above.
- Undefined: no counter register; `StallCount` is tied to 0. All other behaviour is identical.

## Test plan
- `lw $2` in EX, `add $3,$2,$4` in ID (`IFIDRs`=2) -> 1 cycle with `PCWrite`=0 and `IDEXBubble`=1, then `PCWrite`=1; `StallCount` 0→1.
- `lw $5` in EX, `beq $5,$6` in ID -> `Stall`=1 for exactly 2 consecutive cycles (`RUN`→`HOLD`→`RUN`); `StallCount`=2.
- `add $7` in EX, `beq $1,$7` in ID with `BranchTaken`=1 -> cycle 1: `Stall`=1, `IFIDFlush`=0; cycle 2 (bubble in EX): `IFIDFlush`=1, `PCWrite`=1.
- `lw $0` in EX, `add $3,$0,$0` in ID -> no stall. Separately, `Jump`=1 with no hazard -> `IFIDFlush`=1 for 1 cycle.
- `rst`=1 in the `HOLD` cycle -> outputs at reset values; next cycle `RUN`, `StallCount`=0.
- Preload `StallCount` to all-ones (force), then one load-use stall -> value remains all-ones. With the macro undefined, `StallCount`=0 throughout all scenarios.
